quad_step_sched: RTL
====================

# quad_step_sched

Step scheduler for the emulated quadrature steering input. Two requesters share one quadrature output: the joystick front end (port A) and a secondary source such as a mouse/spinner delta or demo playback (port B). Each requester submits a burst of N steps in one direction. The block arbitrates round-robin, then sequences the burst as Gray-code phase transitions on `steer`. Step spacing comes from a programmable base period, and the rate accelerates as the burst proceeds. `steer` feeds the game core's quadrature decoder directly.

## Interface
- `CNT_W`, default 8: width of the step-count field of a request.
- `CLK` input 1: system clock; all state updates on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `clkdiv` input 32: base step period in CLK cycles; sampled at every timer reload.
- `abort` input 1: cancels the burst in progress.
- `a_valid` input 1: requester A has a request pending.
- `a_dir` input 1: direction; 0 = left/reverse, 1 = right/forward.
- `a_cnt` input CNT_W: number of steps in A's burst.
- `a_ready` output 1: A's request is accepted this cycle.
- `b_valid`, `b_dir`, `b_cnt`, `b_ready`: the same fields for requester B.
- `steer` output 2: quadrature phase pair {A,B}.
- `busy` output 1: high while a burst is running.
- `owner` output 1: source of the current or last burst; 0 = A, 1 = B.
- `done` output 1: one-cycle pulse on the cycle the last step of a burst is issued.

## Operation
**States**
- IDLE: no burst running.
- RUN: a burst is running.

**Arbitration (IDLE only)**
- `last` pointer; reset value 1, so A wins first.
- `a_ready = IDLE & a_valid & (!b_valid | last==1)`.
- `b_ready = IDLE & b_valid & (!a_valid | last==0)`.
- The ready signals are combinational from state, valid and `last`. At most one is high.
- Accept = valid & ready. On accept:
  - latch dir and cnt;
  - `last` and `owner` are set to the winner;
  - `accel` is cleared to 0 and `stepn` to 0;
  - timer is loaded with P0-1.
- If cnt ≠ 0, go to RUN. If cnt = 0, stay in IDLE and pulse `done` on the accept cycle with no step.

**Period**
- P = `clkdiv >> accel`, forced to 1 if the result is 0.
- Computed in 32 bits; `accel` is 2 bits.

**RUN**
- Timer ≠ 0: decrement it.
- Timer = 0:
  - Issue one step: advance `steer` one phase and decrement remaining.
  - Increment `stepn` (2 bits). When `stepn` wraps 3→0, `accel` increments, saturating at 3.
  - Reload the timer with P-1 using the updated `accel`.
  - If remaining reaches 0, go to IDLE and pulse `done`.

**Phase sequence**
- Forward (dir=1): 00→10→11→01→00.
- Reverse (dir=0): 00→01→11→10→00.
- `steer` is never forced back to 00 between bursts. Phase persists, so consecutive bursts continue the sequence.

**Abort**
- `abort` in RUN: next state is IDLE, no further steps, `steer` holds, no `done` pulse.
- `abort` in IDLE: ignored, and it does not block accepts.

**Outputs**
- `busy` = (state == RUN).

**Reset**
- Asynchronous reset takes effect at any time, including mid-burst.
- Reset values: `steer`=00, state=IDLE, `busy`=0, `done`=0, `owner`=0, `last`=1, `accel`=0, timer=0, `a_ready`=`b_ready`=0.

## Timing
- Accept at cycle T. For a constant P, step k (1-based) is visible on `steer` at T+k·P. In general, the gap between steps equals the period in force at the previous reload.
- Minimum step spacing is 1 cycle (`clkdiv` ≤ 1 at any `accel`).
- `done` is asserted on the same cycle the final `steer` change becomes visible.
- Earliest next accept is the cycle after `done`; the block is in IDLE at that point.
- A `clkdiv` change mid-burst takes effect at the next reload only.
- Requests are not queued. A requester holds valid until it sees ready.

## Test plan
- **Single burst:** reset, `clkdiv`=8, A requests dir=1, cnt=6 at T → `steer` 10,11,01,00,10,11 at T+8, 16, 24, 32, 36, 40; `done` at T+40; `busy` low at T+41.
- **Simultaneous requests:** A and B valid together after reset → A granted first; after A's `done`, B is granted next even though A is still valid. Then alternate A, B, A with `owner` tracking each burst.
- **Reverse and persistence:** with `steer`=11, B requests dir=0, cnt=3 → 10, 00, 01; `steer` holds 01 afterwards.
- **Edge values:**
  - cnt=0 → `done` on the accept cycle, `steer` unchanged, `busy` never high.
  - `clkdiv`=0, cnt=4 → one step per cycle, at T+1..T+4.
- **Abort and saturation:**
  - `abort` after step 2 of cnt=10 → IDLE next cycle, `steer` frozen, no `done`.
  - `clkdiv`=64, cnt=16 → gaps 64×4, 32×4, 16×4, 8×4; `accel` stays at 3.
- **Reset mid-burst:** assert `RST_N` low mid-burst → `steer`=00, `busy`=0, `a_ready`/`b_ready`=0 immediately. After release, A wins arbitration against simultaneous B.

Source files
------------

// File: rtl/quad_step_sched.sv
// quad_step_sched: round-robin step scheduler that drives an emulated
// quadrature pair. Two requesters submit step bursts; the winner's burst is
// played out as Gray-code phase transitions whose spacing starts at clkdiv
// and halves every four steps (up to three times).
module quad_step_sched #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      clkdiv,
    input  logic             abort,
    input  logic             a_valid,
    input  logic             a_dir,
    input  logic [CNT_W-1:0] a_cnt,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic             b_dir,
    input  logic [CNT_W-1:0] b_cnt,
    output logic             b_ready,
    output logic [1:0]       steer,
    output logic             busy,
    output logic             owner,
    output logic             done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state_q, state_d;
    logic [1:0]       steer_q, steer_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [1:0]       accel_q, accel_d;
    logic [1:0]       stepn_q, stepn_d;
    logic [31:0]      timer_q, timer_d;
    logic             done_q, done_d;

    logic             win_b;
    logic             win_dir;
    logic [CNT_W-1:0] win_cnt;
    logic [1:0]       accel_n;

    // Timer reload value: period is clkdiv shifted by the acceleration level,
    // never shorter than one cycle.
    function automatic logic [31:0] reload_val(input logic [31:0] div,
                                               input logic [1:0]  acc);
        logic [31:0] p;
        p = div >> acc;
        if (p == 32'd0) begin
            p = 32'd1;
        end
        return p - 32'd1;
    endfunction

    // Next Gray phase: forward 00->10->11->01, reverse walks the other way.
    function automatic logic [1:0] next_phase(input logic [1:0] ph,
                                              input logic       fwd);
        logic [1:0] n;
        case (ph)
            2'b00:   n = fwd ? 2'b10 : 2'b01;
            2'b10:   n = fwd ? 2'b11 : 2'b00;
            2'b11:   n = fwd ? 2'b01 : 2'b10;
            default: n = fwd ? 2'b00 : 2'b11;
        endcase
        return n;
    endfunction

    // Arbitration, burst sequencing and next-state selection.
    always_comb begin
        state_d = state_q;
        steer_d = steer_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        last_d  = last_q;
        owner_d = owner_q;
        accel_d = accel_q;
        stepn_d = stepn_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        accel_n = accel_q;

        // Ready is held low while reset is asserted so nothing looks accepted.
        a_ready = RST_N && (state_q == IDLE) && a_valid && (!b_valid || last_q);
        b_ready = RST_N && (state_q == IDLE) && b_valid && (!a_valid || !last_q);

        win_b   = b_ready;
        win_dir = b_ready ? b_dir : a_dir;
        win_cnt = b_ready ? b_cnt : a_cnt;

        case (state_q)
            IDLE: begin
                if (a_ready || b_ready) begin
                    dir_d   = win_dir;
                    rem_d   = win_cnt;
                    last_d  = win_b;
                    owner_d = win_b;
                    accel_d = 2'd0;
                    stepn_d = 2'd0;
                    timer_d = reload_val(clkdiv, 2'd0);
                    if (win_cnt != CNT_ZERO) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (timer_q != 32'd0) begin
                    timer_d = timer_q - 32'd1;
                end else begin
                    steer_d = next_phase(steer_q, dir_q);
                    rem_d   = rem_q - CNT_ONE;
                    stepn_d = stepn_q + 2'd1;
                    if ((stepn_q == 2'd3) && (accel_q != 2'd3)) begin
                        accel_n = accel_q + 2'd1;
                    end
                    accel_d = accel_n;
                    timer_d = reload_val(clkdiv, accel_n);
                    if (rem_q == CNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            steer_q <= 2'b00;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            accel_q <= 2'd0;
            stepn_q <= 2'd0;
            timer_q <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            steer_q <= steer_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            accel_q <= accel_d;
            stepn_q <= stepn_d;
            timer_q <= timer_d;
            done_q  <= done_d;
        end
    end

    assign steer = steer_q;
    assign busy  = (state_q == RUN);
    assign owner = owner_q;
    assign done  = done_q;

endmodule
